sram_read_slave: RTL and testbench
==================================

# sram_read_slave

AXI4 read-channel slave (responder) that serves AR/R transactions from a single-port synchronous SRAM. It is the counterpart of the DMA read master: the master issues ARVALID with INCR bursts, and this block returns RDATA beats with correct RID and RLAST. It sits between an AXI bridge slave port and an SRAM macro. It is read-only: its SRAM write enable is tied inactive, and the write channels are handled elsewhere.

## Interface
Parameters:
- ID_W, 8: AXI ID width (bridge-extended slave ID).
- ADDR_W, 32: AXI address width.
- LEN_W, 4: ARLEN width.
- SRAM_AW, 14: SRAM word-address width (64 KB window).
- BASE_HI, 16'h0001: required ARADDR[31:16] when decode checking is compiled in.

Ports:
- ACLK  in  1  clock; all state changes on the rising edge.
- ARESETn  in  1  reset, asynchronous, active-high (1 = in reset).
- ARID  in  ID_W  read ID.
- ARADDR  in  ADDR_W  byte start address.
- ARLEN  in  LEN_W  beats minus 1.
- ARSIZE  in  3  ignored; every beat is 32-bit.
- ARBURST  in  2  ignored; every burst is treated as INCR.
- ARVALID  in  1  address valid.
- ARREADY  out  1  address ready.
- RID  out  ID_W  returned ID.
- RDATA  out  32  read data.
- RRESP  out  2  2'b00 OKAY, 2'b11 DECERR.
- RLAST  out  1  final beat of the burst.
- RVALID  out  1  data valid.
- RREADY  in  1  master ready.
- CEB  out  1  SRAM chip enable, active-low.
- WEB  out  1  SRAM write enable, active-low; constant 1.
- A  out  SRAM_AW  SRAM word address.
- DO  in  32  SRAM read data, valid one cycle after the CEB=0 edge.

## Operation
- States: IDLE, FETCH, RESP.
- IDLE:
  - ARREADY=1. On ARVALID&&ARREADY: latch ARID, ARADDR[15:0], ARLEN; clear beat counter; go to FETCH.
  - With `SRAM_READ_SLAVE_DECERR_EN` defined and a bad address, go to RESP directly instead (see Configuration).
- FETCH:
  - Drive CEB=0 and A=addr_q[15:2].
  - Next edge: capture DO into the data register and go to RESP.
- RESP:
  - Drive RVALID=1, RDATA=data register, RID=id_q, RRESP=resp_q, RLAST=(beat==len_q).
  - All R outputs hold stable until RREADY.
  - On RVALID&&RREADY with RLAST=1: go to IDLE.
  - On RVALID&&RREADY with RLAST=0: addr_q[15:0]+=4, beat+=1, go to FETCH.
- Address arithmetic is 16-bit. 16'hFFFC+4 wraps to 16'h0000 (SRAM word 0). Upper address bits are never incremented.
- Only one outstanding transaction. ARREADY=0 in FETCH and RESP.
- ARVALID held during a burst is accepted in the first IDLE cycle after the burst.

## Timing
- Reset values:
  - State IDLE, so ARREADY=1 while reset is asserted. No handshake is accepted during reset.
  - RVALID=0, RLAST=0, RID=0, RDATA=0, RRESP=0.
  - CEB=1, WEB=1, A=0.
- Latency: AR handshake at edge N → FETCH in cycle N+1 (CEB=0) → RVALID=1 in cycle N+2.
- Per beat: 2 cycles minimum (FETCH + RESP) when RREADY is held high.
- Throughput: ARLEN=3 with RREADY=1 completes 8 cycles after the AR handshake. The next ARREADY=1 occurs the cycle after the last R handshake.
- RREADY low: RESP holds indefinitely and CEB stays 1.
- Reset asserted mid-burst:
  - Immediate (asynchronous) return to IDLE; RVALID and RLAST drop in the same cycle.
  - The burst is abandoned and is not resumed after reset.
- RREADY asserted before RVALID has no effect.

## Configuration
- `SRAM_READ_SLAVE_DECERR_EN`.
- Defined:
  - If ARADDR[31:16]!=BASE_HI at the AR handshake, latch resp_q=2'b11 and skip FETCH for every beat.
  - Return ARLEN+1 beats with RDATA=32'h0, RRESP=2'b11, correct RLAST; CEB stays 1.
  - One cycle per beat; RVALID appears in cycle N+1.
- Undefined: no decode check, RRESP is always 2'b00, and all addresses map into the SRAM by ARADDR[15:2].

## Test plan
- Single beat: ARID=8'h12, ARADDR=32'h0001_0010, ARLEN=0, SRAM word 4=32'hDEAD_BEEF, RREADY=1 → RVALID in cycle N+2 with RDATA=32'hDEAD_BEEF, RID=8'h12, RLAST=1, RRESP=0; ARREADY=1 on the next cycle.
- 4-beat burst with backpressure: ARADDR=32'h0001_0100, ARLEN=3, words 64..67=1,2,3,4, RREADY low for 3 cycles on beat 2 → beats 1,2,3,4 in order, RDATA stable during the stall, RLAST only on beat 4, CEB=1 during the stall.
- Wrap: ARADDR=32'h0001_FFF8, ARLEN=3 → A sequence 16382, 16383, 0, 1.
- Back-to-back: ARVALID held high across two transactions with IDs 8'h01 and 8'h02 → second accepted the cycle after the first RLAST handshake, with no ID mixing.
- DECERR (macro defined): ARADDR=32'h0002_0000, ARLEN=1 → 2 beats with RRESP=2'b11, RDATA=0, RLAST on beat 2, CEB never 0. With the macro undefined → RRESP=0 and SRAM word 0 is read.
- Reset mid-burst: assert ARESETn during beat 2 of ARLEN=3 → RVALID=0 in the same cycle. After release, a new ARLEN=0 read returns correct data with RLAST=1.

Source files
------------

// File: rtl/sram_read_slave.sv
// sram_read_slave: AXI4 read-channel responder that serves INCR bursts from a
// single-port synchronous SRAM, one outstanding transaction at a time.
//
// Optional feature macro: SRAM_READ_SLAVE_DECERR_EN
//   When defined, ARADDR[ADDR_W-1:16] must equal BASE_HI. A mismatched
//   burst returns ARLEN+1 DECERR beats with zero data and never touches the SRAM.
//
// Ports:
//   ACLK                   clock, rising edge
//   ARESETn                asynchronous reset, active-high (1 = in reset)
//   ARID/ARADDR/ARLEN      read address channel payload
//   ARSIZE/ARBURST         accepted but ignored (32-bit beats, INCR)
//   ARVALID/ARREADY        read address handshake
//   RID/RDATA/RRESP/RLAST  read data channel payload
//   RVALID/RREADY          read data handshake
//   CEB/WEB/A              SRAM chip enable (low), write enable (held high), word address
//   DO                     SRAM read data, sampled at the end of the fetch cycle
module sram_read_slave #(
    parameter int unsigned ID_W    = 8,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned SRAM_AW = 14,
    parameter logic [15:0] BASE_HI = 16'h0001
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [ID_W-1:0]   ARID,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [LEN_W-1:0]  ARLEN,
    input  logic [2:0]        ARSIZE,
    input  logic [1:0]        ARBURST,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [ID_W-1:0]   RID,
    output logic [31:0]       RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    output logic              CEB,
    output logic              WEB,
    output logic [SRAM_AW-1:0] A,
    input  logic [31:0]       DO
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    state_t              state, state_nxt;
    logic [ID_W-1:0]     id_q, id_nxt;
    logic [SRAM_AW-1:0]  addr_q, addr_nxt;
    logic [LEN_W-1:0]    len_q, len_nxt;
    logic [LEN_W-1:0]    beat_q, beat_nxt;
    logic [1:0]          resp_q, resp_nxt;
    logic [31:0]         data_q, data_nxt;
    logic                arready_q, rvalid_q, rlast_q, ceb_q;
    logic                bad_addr;

    // Decode check on the upper address bits (compiled in only with the macro)
`ifdef SRAM_READ_SLAVE_DECERR_EN
    assign bad_addr = (ARADDR[ADDR_W-1:16] != (ADDR_W-16)'(BASE_HI));
`else
    assign bad_addr = 1'b0;
`endif

    // Size/burst fields and byte-lane bits carry no information for this slave
    logic unused_ok;
    assign unused_ok = ^{ARSIZE, ARBURST, ARADDR, BASE_HI};

    // Next-state and datapath update
    always_comb begin
        state_nxt = state;
        id_nxt    = id_q;
        addr_nxt  = addr_q;
        len_nxt   = len_q;
        beat_nxt  = beat_q;
        resp_nxt  = resp_q;
        data_nxt  = data_q;
        case (state)
            IDLE: begin
                if (ARVALID) begin
                    id_nxt   = ARID;
                    addr_nxt = ARADDR[SRAM_AW+1:2];
                    len_nxt  = ARLEN;
                    beat_nxt = '0;
                    if (bad_addr) begin
                        resp_nxt  = RESP_DECERR;
                        data_nxt  = '0;
                        state_nxt = RESP;
                    end else begin
                        resp_nxt  = RESP_OKAY;
                        state_nxt = FETCH;
                    end
                end
            end
            FETCH: begin
                data_nxt  = DO;
                state_nxt = RESP;
            end
            RESP: begin
                if (RREADY) begin
                    if (beat_q == len_q) begin
                        state_nxt = IDLE;
                    end else begin
                        beat_nxt = beat_q + LEN_W'(1);
                        // Word address wraps within the SRAM window
                        addr_nxt = addr_q + SRAM_AW'(1);
                        // DECERR bursts never visit the SRAM
                        state_nxt = (resp_q == RESP_DECERR) ? RESP : FETCH;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, datapath and registered channel outputs
    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            state     <= IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            resp_q    <= RESP_OKAY;
            data_q    <= '0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            ceb_q     <= 1'b1;
        end else begin
            state     <= state_nxt;
            id_q      <= id_nxt;
            addr_q    <= addr_nxt;
            len_q     <= len_nxt;
            beat_q    <= beat_nxt;
            resp_q    <= resp_nxt;
            data_q    <= data_nxt;
            arready_q <= (state_nxt == IDLE);
            rvalid_q  <= (state_nxt == RESP);
            rlast_q   <= (state_nxt == RESP) && (beat_nxt == len_nxt);
            ceb_q     <= (state_nxt != FETCH);
        end
    end

    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RLAST   = rlast_q;
    assign RID     = id_q;
    assign RDATA   = data_q;
    assign RRESP   = resp_q;
    assign CEB     = ceb_q;
    assign WEB     = 1'b1;
    assign A       = addr_q;

endmodule

// File: tb/tb_sram_read_slave.sv
// Scoreboard bench for sram_read_slave: AR handshakes push expected beats and
// SRAM addresses from a behavioural model; an independent monitor checks them.
module tb_sram_read_slave;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [7:0]  ARID = '0;
    logic [31:0] ARADDR = '0;
    logic [3:0]  ARLEN = '0;
    logic [2:0]  ARSIZE = 3'd2;
    logic [1:0]  ARBURST = 2'b01;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [7:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        CEB;
    logic        WEB;
    logic [13:0] A;
    logic [31:0] DO;

`ifdef SRAM_READ_SLAVE_DECERR_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif

    typedef struct {
        logic [7:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [13:0] a_q[$];
    logic [31:0] mem [0:16383];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          ar_edge = 0;
    int          rlast_edge = 0;
    bit          rr_rand = 1'b0;
    bit          rr_manual = 1'b1;
    bit          rr_rnd = 1'b1;
    bit          stall = 1'b0;
    logic [42:0] held = '0;

    sram_read_slave dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .CEB(CEB), .WEB(WEB), .A(A), .DO(DO)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    // SRAM: data valid by the edge that ends the CEB=0 cycle; junk otherwise
    assign DO = CEB ? 32'hA5A5_5A5A : mem[A];

    assign RREADY = rr_rand ? rr_rnd : rr_manual;
    always @(posedge ACLK) begin
        #1;
        rr_rnd = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, expv);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // Reference model: 16-bit byte-address arithmetic, one beat per 4 bytes
    task automatic model_push(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
        logic [15:0] a16;
        beat_t       e;
        bit          bad;
        bad = DEC && (addr[31:16] != 16'h0001);
        for (int b = 0; b <= int'(len); b++) begin
            a16    = addr[15:0] + 16'(4 * b);
            e.id   = id;
            e.last = (b == int'(len));
            if (bad) begin
                e.data = 32'h0;
                e.resp = 2'b11;
            end else begin
                e.data = mem[a16[15:2]];
                e.resp = 2'b00;
                a_q.push_back(a16[15:2]);
            end
            exp_q.push_back(e);
        end
    endtask

    // AR monitor: handshake seen at negedge completes on the next rising edge
    always @(negedge ACLK) begin
        if (!ARESETn && ARVALID && ARREADY) begin
            model_push(ARID, ARADDR, ARLEN);
            ar_edge = cyc + 1;
        end
    end

    // R / SRAM monitor
    always @(negedge ACLK) begin
        beat_t e;
        if (ARESETn) begin
            stall = 1'b0;
        end else begin
            if (!CEB) begin
                if (a_q.size() == 0) fail("sram_access_unexpected");
                else chk("sram_addr", 64'(A), 64'(a_q.pop_front()));
            end
            if (RVALID) begin
                chk("ceb_high_in_resp", 64'(CEB), 64'd1);
                if (stall) chk("r_stable_in_stall", 64'({RID, RDATA, RRESP, RLAST}), 64'(held));
                if (RREADY) begin
                    if (exp_q.size() == 0) begin
                        fail("r_beat_unexpected");
                    end else begin
                        e = exp_q.pop_front();
                        chk("rdata", 64'(RDATA), 64'(e.data));
                        chk("rid", 64'(RID), 64'(e.id));
                        chk("rresp", 64'(RRESP), 64'(e.resp));
                        chk("rlast", 64'(RLAST), 64'(e.last));
                    end
                    if (RLAST) rlast_edge = cyc + 1;
                end
                stall = !RREADY;
                held  = {RID, RDATA, RRESP, RLAST};
            end else begin
                if (stall) fail("rvalid_dropped_in_stall");
                stall = 1'b0;
            end
        end
    end

    task automatic issue(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len, input bit keep);
        int n = 0;
        ARID    = id;
        ARADDR  = addr;
        ARLEN   = len;
        ARSIZE  = 3'($urandom);
        ARBURST = 2'($urandom);
        ARVALID = 1'b1;
        do begin
            @(negedge ACLK);
            n++;
        end while (!ARREADY && n < 3000);
        if (!ARREADY) fail("ar_handshake_timeout");
        @(posedge ACLK);
        #1;
        if (!keep) ARVALID = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!(exp_q.size() == 0 && a_q.size() == 0 && ARREADY) && n < 3000);
        if (n >= 3000) fail({name, "_timeout"});
        @(posedge ACLK);
        #1;
    endtask

    task automatic wait_rvalid(input string name);
        int n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!RVALID && n < 100);
        if (!RVALID) fail({name, "_rvalid_timeout"});
    endtask

    initial begin
        int e0;
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        mem[4] = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) mem[64 + i] = 32'(i + 1);

        // Reset: outputs at reset values; ARVALID during reset is not accepted
        #1 ARESETn = 1'b1;
        ARID = 8'h77; ARADDR = 32'h0001_0000; ARVALID = 1'b1;
        repeat (3) @(negedge ACLK);
        chk("rst_arready", 64'(ARREADY), 64'd1);
        chk("rst_rvalid", 64'(RVALID), 64'd0);
        chk("rst_rlast", 64'(RLAST), 64'd0);
        chk("rst_rid", 64'(RID), 64'd0);
        chk("rst_rdata", 64'(RDATA), 64'd0);
        chk("rst_rresp", 64'(RRESP), 64'd0);
        chk("rst_ceb", 64'(CEB), 64'd1);
        chk("rst_web", 64'(WEB), 64'd1);
        chk("rst_a", 64'(A), 64'd0);
        ARVALID = 1'b0;
        @(posedge ACLK); #1 ARESETn = 1'b0;
        repeat (3) @(negedge ACLK);
        chk("post_rst_rvalid", 64'(RVALID), 64'd0);
        @(posedge ACLK); #1;

        // Single beat with latency
        issue(8'h12, 32'h0001_0010, 4'd0, 1'b0);
        @(negedge ACLK);
        chk("lat_fetch_rvalid", 64'(RVALID), 64'd0);
        chk("lat_fetch_ceb", 64'(CEB), 64'd0);
        chk("lat_fetch_a", 64'(A), 64'd4);
        @(negedge ACLK);
        chk("lat_rvalid", 64'(RVALID), 64'd1);
        chk("single_rdata", 64'(RDATA), 64'hDEAD_BEEF);
        chk("single_rlast", 64'(RLAST), 64'd1);
        @(negedge ACLK);
        chk("arready_after_last", 64'(ARREADY), 64'd1);
        @(posedge ACLK); #1;

        // Throughput: 4 beats complete 8 edges after the AR handshake
        issue(8'h21, 32'h0001_0200, 4'd3, 1'b0);
        e0 = ar_edge;
        wait_done("thru");
        chk("thru_edges", 64'(rlast_edge - e0), 64'd8);

        // 4-beat burst with 3-cycle stall on beat 2
        issue(8'h34, 32'h0001_0100, 4'd3, 1'b0);
        wait_rvalid("bp_beat1");
        @(posedge ACLK); #1 rr_manual = 1'b0;
        wait_rvalid("bp_beat2");
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge ACLK);
            chk("bp_stall_ceb", 64'(CEB), 64'd1);
            chk("bp_stall_rdata", 64'(RDATA), 64'd2);
            chk("bp_stall_rlast", 64'(RLAST), 64'd0);
        end
        @(posedge ACLK); #1 rr_manual = 1'b1;
        wait_done("bp");

        // Address wrap at the top of the 64 KB window
        issue(8'h5A, 32'h0001_FFF8, 4'd3, 1'b0);
        wait_done("wrap");

        // Back-to-back with ARVALID held
        issue(8'h01, 32'h0001_0300, 4'd1, 1'b1);
        issue(8'h02, 32'h0001_0400, 4'd0, 1'b0);
        chk("b2b_gap", 64'(ar_edge - rlast_edge), 64'd1);
        wait_done("b2b");

        // Out-of-window address
        issue(8'h66, 32'h0002_0000, 4'd1, 1'b0);
        @(negedge ACLK);
        chk("decerr_first_rvalid", 64'(RVALID), 64'(DEC));
        wait_done("decerr");

        // Reset during beat 2 of a 4-beat burst
        issue(8'h70, 32'h0001_0500, 4'd3, 1'b0);
        wait_rvalid("rst_beat1");
        @(posedge ACLK); #1;
        wait_rvalid("rst_beat2");
        #2 ARESETn = 1'b1;
        #1;
        chk("midrst_rvalid", 64'(RVALID), 64'd0);
        chk("midrst_rlast", 64'(RLAST), 64'd0);
        chk("midrst_arready", 64'(ARREADY), 64'd1);
        chk("midrst_ceb", 64'(CEB), 64'd1);
        exp_q.delete();
        a_q.delete();
        @(posedge ACLK); #1 ARESETn = 1'b0;
        repeat (4) @(negedge ACLK);
        chk("midrst_no_resume", 64'(RVALID), 64'd0);
        @(posedge ACLK); #1;
        issue(8'h78, 32'h0001_0600, 4'd0, 1'b0);
        wait_done("after_rst");

        // Randomized traffic with random backpressure
        rr_rand = 1'b1;
        for (int t = 0; t < 40; t++) begin
            logic [15:0] hi;
            hi = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0001;
            issue(8'($urandom), {hi, 16'($urandom)}, 4'($urandom), 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge ACLK);
            #1;
        end
        wait_done("random");
        rr_rand = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        fail("global_timeout");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
